// File: rtl/mem_access.sv
// mem_access: RV32I load/store stage over a single-outstanding req/ack data port; non-memory and faulting ops retire in 1 cycle,
// legal memory ops in 2 cycles plus memory wait; Stall is held from issue until the response (or timeout) is taken.
module mem_access #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        InValid,
   input  logic [31:0] instruction,
   input  logic [31:0] ALUresult,
   input  logic [31:0] Reg2RD,
   output logic        Stall,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic [3:0]  MemWStrb,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic        OutValid,
   output logic        RegWEn,
   output logic [4:0]  RegWAddr,
   output logic [31:0] RegWData,
   output logic        MemFault
);

   localparam logic [6:0]       OP_LOAD   = 7'b0000011;
   localparam logic [6:0]       OP_STORE  = 7'b0100011;
   localparam logic [6:0]       OP_BRANCH = 7'b1100011;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // Captured attributes of the in-flight access, needed once the response arrives.
   logic             op_load, op_load_nx;
   logic [2:0]       op_f3, op_f3_nx;
   logic [1:0]       op_a, op_a_nx;
   logic [4:0]       op_rd, op_rd_nx;

   logic             memreq_nx, memwe_nx, outvalid_nx, regwen_nx, memfault_nx;
   logic [31:0]      memaddr_nx, memwdata_nx, regwdata_nx;
   logic [3:0]       memwstrb_nx;
   logic [4:0]       regwaddr_nx;
   logic             stall_c;

   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [2:0]       funct3;
   logic [1:0]       a;
   logic             is_load, is_store, is_mem, f3_ok, misalign, req_fault;
   logic [3:0]       st_strb;
   logic [31:0]      st_data;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_val;
   logic             unused_ins;

   assign opcode     = instruction[6:0];
   assign rd         = instruction[11:7];
   assign funct3     = instruction[14:12];
   assign a          = ALUresult[1:0];
   assign unused_ins = ^instruction[31:15];

   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_mem   = is_load | is_store;

   // Loads reject 011/110/111; stores accept only 000/001/010.
   assign f3_ok     = is_load ? ((funct3 != 3'b011) && (funct3[2:1] != 2'b11))
                              : (!funct3[2] && (funct3[1:0] != 2'b11));
   assign misalign  = ((funct3[1:0] == 2'b01) && a[0]) ||
                      ((funct3[1:0] == 2'b10) && (a != 2'b00));
   assign req_fault = !f3_ok || misalign;

   always_comb begin
      st_strb = 4'b1111;
      st_data = Reg2RD;
      case (funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << a;
            st_data = {4{Reg2RD[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {a[1], 1'b0};
            st_data = {2{Reg2RD[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = MemRData[7:0];
      case (op_a)
         2'b01:   ld_byte = MemRData[15:8];
         2'b10:   ld_byte = MemRData[23:16];
         2'b11:   ld_byte = MemRData[31:24];
         default: ;
      endcase
      ld_half = op_a[1] ? MemRData[31:16] : MemRData[15:0];
      case (op_f3)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_val = {24'h0, ld_byte};
         3'b101:  ld_val = {16'h0, ld_half};
         default: ld_val = MemRData;
      endcase
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      op_load_nx  = op_load;
      op_f3_nx    = op_f3;
      op_a_nx     = op_a;
      op_rd_nx    = op_rd;
      memreq_nx   = MemReq;
      memwe_nx    = MemWe;
      memaddr_nx  = MemAddr;
      memwdata_nx = MemWData;
      memwstrb_nx = MemWStrb;
      outvalid_nx = 1'b0;
      regwen_nx   = RegWEn;
      regwaddr_nx = RegWAddr;
      regwdata_nx = RegWData;
      memfault_nx = MemFault;
      stall_c     = 1'b0;

      case (state)
         IDLE: begin
            if (InValid) begin
               if (!is_mem) begin
                  outvalid_nx = 1'b1;
                  memfault_nx = 1'b0;
                  regwen_nx   = (rd != 5'd0) && (opcode != OP_BRANCH);
                  regwaddr_nx = rd;
                  regwdata_nx = ALUresult;
               end else if (req_fault) begin
                  outvalid_nx = 1'b1;
                  memfault_nx = 1'b1;
                  regwen_nx   = 1'b0;
                  regwaddr_nx = rd;
               end else begin
                  stall_c     = 1'b1;
                  memreq_nx   = 1'b1;
                  memwe_nx    = is_store;
                  memaddr_nx  = {ALUresult[31:2], 2'b00};
                  memwdata_nx = is_store ? st_data : 32'h0;
                  memwstrb_nx = is_store ? st_strb : 4'b0000;
                  op_load_nx  = is_load;
                  op_f3_nx    = funct3;
                  op_a_nx     = a;
                  op_rd_nx    = rd;
                  cnt_nx      = '0;
                  state_nx    = WAIT;
               end
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            cnt_nx  = cnt + CNT_W'(1);
            // An ack arriving on the last allowed cycle still completes normally.
            if (MemAck) begin
               memreq_nx   = 1'b0;
               outvalid_nx = 1'b1;
               memfault_nx = 1'b0;
               regwen_nx   = op_load && (op_rd != 5'd0);
               regwaddr_nx = op_rd;
               if (op_load) regwdata_nx = ld_val;
               state_nx    = DONE;
            end else if (cnt == CNT_LAST) begin
               memreq_nx   = 1'b0;
               outvalid_nx = 1'b1;
               memfault_nx = 1'b1;
               regwen_nx   = 1'b0;
               regwaddr_nx = op_rd;
               state_nx    = DONE;
            end
         end
         DONE: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The issue-cycle stall is combinational, so it must also fall with reset.
   assign Stall = stall_c & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         op_load  <= 1'b0;
         op_f3    <= 3'b000;
         op_a     <= 2'b00;
         op_rd    <= 5'd0;
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= 32'h0;
         MemWData <= 32'h0;
         MemWStrb <= 4'b0000;
         OutValid <= 1'b0;
         RegWEn   <= 1'b0;
         RegWAddr <= 5'd0;
         RegWData <= 32'h0;
         MemFault <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         op_load  <= op_load_nx;
         op_f3    <= op_f3_nx;
         op_a     <= op_a_nx;
         op_rd    <= op_rd_nx;
         MemReq   <= memreq_nx;
         MemWe    <= memwe_nx;
         MemAddr  <= memaddr_nx;
         MemWData <= memwdata_nx;
         MemWStrb <= memwstrb_nx;
         OutValid <= outvalid_nx;
         RegWEn   <= regwen_nx;
         RegWAddr <= regwaddr_nx;
         RegWData <= regwdata_nx;
         MemFault <= memfault_nx;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against an arithmetic reference of RV32I load/store rules.
module tb_mem_access;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        InValid;
   logic [31:0] instruction, ALUresult, Reg2RD;
   logic        Stall, MemReq, MemWe;
   logic [31:0] MemAddr, MemWData;
   logic [3:0]  MemWStrb;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        OutValid, RegWEn;
   logic [4:0]  RegWAddr;
   logic [31:0] RegWData;
   logic        MemFault;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .InValid(InValid), .instruction(instruction),
      .ALUresult(ALUresult), .Reg2RD(Reg2RD), .Stall(Stall), .MemReq(MemReq),
      .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemWStrb(MemWStrb),
      .MemAck(MemAck), .MemRData(MemRData), .OutValid(OutValid), .RegWEn(RegWEn),
      .RegWAddr(RegWAddr), .RegWData(RegWData), .MemFault(MemFault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      logic [31:0] hi;
      hi = $urandom;
      return {hi[31:15], f3, rd, op};
   endfunction

   // Reference: what the stage must produce for one instruction, given the word memory returns.
   task automatic model(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] rword, output bit is_mem, output bit fault,
                        output bit wen, output bit store, output logic [31:0] wval,
                        output logic [3:0] strb, output logic [31:0] mwd);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] v, mask;
      int nb, sh;
      bit load, legal;
      op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
      load   = (op == 7'h03);
      store  = (op == 7'h23);
      is_mem = load || store;
      case (f3[1:0])
         2'd0: nb = 1;
         2'd1: nb = 2;
         2'd2: nb = 4;
         default: nb = 0;
      endcase
      legal = load ? (f3 != 3 && f3 != 6 && f3 != 7) : (f3 < 3);
      sh    = int'(alu[1:0]);
      fault = is_mem && (!legal || (nb != 0 && (sh % nb) != 0));
      mask  = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v     = (rword >> (8 * sh)) & mask;
      if (!f3[2] && nb > 0 && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      wval  = load ? v : alu;
      if (fault)      wen = 1'b0;
      else if (load)  wen = (rd != 0);
      else if (store) wen = 1'b0;
      else            wen = (rd != 0) && (op != 7'h63);
      strb = 4'(((32'd1 << nb) - 32'd1) << sh);
      mwd  = 32'h0;
      if (nb > 0)
         for (int i = 0; i < 4; i++) mwd[8*i +: 8] = rs2[8*(i % nb) +: 8];
   endtask

   // Called at a falling edge with the DUT idle; ack_wait = WAIT cycle carrying MemAck, 0 = never.
   task automatic run_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rword, input int ack_wait);
      bit is_mem, fault, wen, store, got_out, exp_fault, exp_wen;
      logic [31:0] wval, mwd, exp_addr;
      logic [3:0]  strb;
      int nw, holderr, exp_wait;
      model(ins, alu, rs2, rword, is_mem, fault, wen, store, wval, strb, mwd);
      instruction = ins; ALUresult = alu; Reg2RD = rs2; InValid = 1'b1;
      MemAck = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      check("issue_stall", 32'(Stall), 32'(is_mem && !fault));
      @(posedge clk); @(negedge clk);
      MemAck = 1'b0;
      if (!is_mem || fault) begin
         check("quick_outvalid", 32'(OutValid), 32'd1);
         check("quick_memreq", 32'(MemReq), 32'd0);
         check("quick_fault", 32'(MemFault), 32'(fault));
         check("quick_regwen", 32'(RegWEn), 32'(wen));
         if (wen) begin
            check("quick_regwaddr", 32'(RegWAddr), 32'(ins[11:7]));
            check("quick_regwdata", RegWData, wval);
         end
         InValid = 1'b0;
         @(posedge clk); @(negedge clk);
         check("quick_pulse", 32'(OutValid), 32'd0);
      end else begin
         exp_addr = {alu[31:2], 2'b00};
         check("memaddr", MemAddr, exp_addr);
         check("memwe", 32'(MemWe), 32'(store));
         if (store) begin
            check("memwstrb", 32'(MemWStrb), 32'(strb));
            check("memwdata", MemWData, mwd);
         end
         nw = 0; holderr = 0; got_out = 1'b0;
         for (int n = 1; n <= TIMEOUT + 4 && !got_out; n++) begin
            if (OutValid) got_out = 1'b1;
            else begin
               if (Stall) nw++;
               if (!MemReq || MemAddr !== exp_addr) holderr++;
               MemAck   = (n == ack_wait);
               MemRData = MemAck ? rword : $urandom;
               @(posedge clk); #1 MemAck = 1'b0;
               @(negedge clk);
            end
         end
         check("response_seen", 32'(got_out), 32'd1);
         exp_fault = !(ack_wait >= 1 && ack_wait <= TIMEOUT);
         exp_wait  = exp_fault ? TIMEOUT : ack_wait;
         exp_wen   = !exp_fault && wen;
         check("wait_cycles", 32'(nw), 32'(exp_wait));
         check("req_hold", 32'(holderr), 32'd0);
         check("done_memreq", 32'(MemReq), 32'd0);
         check("done_stall", 32'(Stall), 32'd0);
         check("done_fault", 32'(MemFault), 32'(exp_fault));
         check("done_regwen", 32'(RegWEn), 32'(exp_wen));
         if (exp_wen) begin
            check("done_regwaddr", 32'(RegWAddr), 32'(ins[11:7]));
            check("done_regwdata", RegWData, wval);
         end
         @(posedge clk); #1 InValid = 1'b0;
         @(negedge clk);
         check("done_pulse", 32'(OutValid), 32'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int spurious;
      int cls;
      logic [6:0] op;
      logic [31:0] ins;

      rst_n = 1'b0; InValid = 1'b0; instruction = '0; ALUresult = '0; Reg2RD = '0;
      MemAck = 1'b0; MemRData = '0;
      repeat (3) @(negedge clk);
      check("rst_outvalid", 32'(OutValid), 32'd0);
      check("rst_memreq", 32'(MemReq), 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);
      check("rst_regwen", 32'(RegWEn), 32'd0);
      check("rst_regwdata", RegWData, 32'd0);
      check("rst_memfault", 32'(MemFault), 32'd0);
      check("rst_memaddr", MemAddr, 32'd0);
      check("rst_memwstrb", 32'(MemWStrb), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(mk(7'h33, 3'b000, 5'd5), 32'h0000_1234, 32'h0, 32'h0, 1);
      run_op(mk(7'h03, 3'b000, 5'd9), 32'h0000_1003, 32'h0, 32'h80FF_0000, 2);
      run_op(mk(7'h03, 3'b100, 5'd9), 32'h0000_1003, 32'h0, 32'h80FF_0000, 2);
      run_op(mk(7'h23, 3'b001, 5'd3), 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 1);
      run_op(mk(7'h03, 3'b010, 5'd4), 32'h0000_3001, 32'h0, 32'h0, 1);
      run_op(mk(7'h23, 3'b010, 5'd0), 32'h0000_4000, 32'h1234_5678, 32'h0, 0);
      run_op(mk(7'h23, 3'b010, 5'd0), 32'h0000_4004, 32'h1234_5678, 32'h0, TIMEOUT);
      run_op(mk(7'h03, 3'b001, 5'd6), 32'h0000_5002, 32'h0, 32'h8001_7FFF, 3);
      run_op(mk(7'h03, 3'b010, 5'd0), 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 1);
      run_op(mk(7'h63, 3'b000, 5'd7), 32'h0000_0040, 32'h0, 32'h0, 1);
      run_op(mk(7'h03, 3'b110, 5'd8), 32'h0000_7000, 32'h0, 32'h0, 1);

      // Reset while a store is waiting for its ack.
      instruction = mk(7'h23, 3'b010, 5'd0); ALUresult = 32'h0000_8000; Reg2RD = 32'hA5A5_A5A5;
      InValid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("wait_memreq", 32'(MemReq), 32'd1);
      @(posedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_memreq", 32'(MemReq), 32'd0);
      check("midrst_stall", 32'(Stall), 32'd0);
      InValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (5) begin
         @(negedge clk);
         if (OutValid || MemReq || Stall) spurious++;
      end
      check("postrst_quiet", 32'(spurious), 32'd0);
      run_op(mk(7'h03, 3'b101, 5'd12), 32'h0000_9002, 32'h0, 32'h8001_7FFF, 2);

      for (int i = 0; i < 60; i++) begin
         cls = $urandom_range(0, 3);
         case (cls)
            1: op = 7'h03;
            2: op = 7'h23;
            3: op = 7'h63;
            default: begin
               op = 7'($urandom);
               if (op == 7'h03 || op == 7'h23) op = 7'h13;
            end
         endcase
         ins = mk(op, 3'($urandom_range(0, 7)), 5'($urandom));
         run_op(ins, $urandom, $urandom, $urandom, $urandom_range(1, 6));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
